// File: rtl/npn_pkg.sv
// Shared definitions for the NPN truth-table stream evaluator.
//
// Contents:
//   DEFAULT_TT_4IN  truth table loaded at reset for the 4-input default
//   perm_vec_t      permutation vector sized for the largest supported input count
//   idx_w()         permutation field width for an n-input function
//   identity_perm() packed permutation with field k = k
//   perm_ok()       checks that a packed permutation is a true permutation of 0..n-1
package npn_pkg;

  localparam int unsigned MAX_INPUTS = 6;
  localparam int unsigned MAX_IDX_W  = 3;
  localparam int unsigned MAX_PERM_W = MAX_INPUTS * MAX_IDX_W;

  localparam logic [15:0] DEFAULT_TT_4IN = 16'h1689;

  typedef logic [MAX_PERM_W-1:0] perm_vec_t;

  // Smallest width w >= 1 with 2**w >= n.
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 8; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic perm_vec_t identity_perm(input int unsigned n);
    perm_vec_t    p;
    int unsigned  w;
    p = '0;
    w = idx_w(n);
    for (int unsigned k = 0; k < MAX_INPUTS; k++) begin
      if (k < n) p = p | (perm_vec_t'(k) << (k * w));
    end
    return p;
  endfunction

  // Valid when every field is in range and no source index is used twice.
  function automatic logic perm_ok(input perm_vec_t perm, input int unsigned n);
    logic         ok;
    logic [7:0]   seen;
    int unsigned  w;
    int unsigned  f;
    ok   = 1'b1;
    seen = '0;
    w    = idx_w(n);
    for (int unsigned k = 0; k < MAX_INPUTS; k++) begin
      if (k < n) begin
        f = 32'((perm >> (k * w)) & ((perm_vec_t'(1) << w) - perm_vec_t'(1)));
        if (f >= n) begin
          ok = 1'b0;
        end else if (seen[f[2:0]]) begin
          ok = 1'b0;
        end else begin
          seen[f[2:0]] = 1'b1;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/npn_xform.sv
// Combinational input transform: negate selected inputs, then permute.
//
// Ports:
//   x     raw input vector
//   neg   per-input negation mask, applied before permutation
//   perm  packed fields; field k selects the source input for output bit k
//   y     transformed vector, y[k] = (x ^ neg)[perm field k]
module npn_xform
  import npn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned IDX_W      = idx_w(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]       x,
  input  logic [NUM_INPUTS-1:0]       neg,
  input  logic [NUM_INPUTS*IDX_W-1:0] perm,
  output logic [NUM_INPUTS-1:0]       y
);

  // Pad to a power of two so every field value indexes a real bit; out-of-range
  // fields never reach here because the top rejects them at configuration.
  localparam int unsigned VW = 1 << IDX_W;

  logic [VW-1:0] v;

  always_comb begin
    v = VW'(x ^ neg);
    y = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      y[k] = v[perm[k*IDX_W +: IDX_W]];
    end
  end

endmodule

// File: rtl/npn_lut_stream.sv
// Streaming evaluator for one programmable N-input Boolean function with a
// runtime NPN transform (input negation, input permutation, output negation).
//
// Two-stage elastic pipeline:
//   stage 1  registers the negated/permuted input vector
//   stage 2  registers the truth-table lookup, optionally inverted
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   cfg_valid   configuration offered; blocks new inputs so the pipeline drains
//   cfg_ready   high only when both stages are empty and rst is low
//   cfg_tt      truth table, bit i = f(index i)
//   cfg_neg     input negation mask
//   cfg_perm    packed permutation, field k = source input of transformed input k
//   cfg_oneg    output negation
//   cfg_err     one-cycle pulse after an accepted but rejected configuration
//   in_valid    input vector offered
//   in_ready    input accepted when both high
//   in_x        input vector
//   out_valid   result valid, held under backpressure
//   out_ready   downstream accepts
//   out_y       result, stable while out_valid & ~out_ready
//   eval_count  saturating count of delivered results
module npn_lut_stream
  import npn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned TT_W       = 1 << NUM_INPUTS,
  parameter int unsigned IDX_W      = idx_w(NUM_INPUTS),
  parameter logic [63:0] DEFAULT_TT = 64'(DEFAULT_TT_4IN),
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [TT_W-1:0]             cfg_tt,
  input  logic [NUM_INPUTS-1:0]       cfg_neg,
  input  logic [NUM_INPUTS*IDX_W-1:0] cfg_perm,
  input  logic                        cfg_oneg,
  output logic                        cfg_err,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS-1:0]       in_x,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_y,
  output logic [CNT_W-1:0]            eval_count
);

  localparam int unsigned         PERM_W   = NUM_INPUTS * IDX_W;
  localparam logic [TT_W-1:0]     RST_TT   = DEFAULT_TT[TT_W-1:0];
  localparam logic [PERM_W-1:0]   RST_PERM = PERM_W'(identity_perm(NUM_INPUTS));
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  // Configuration registers
  logic [TT_W-1:0]       tt_q,   tt_d;
  logic [NUM_INPUTS-1:0] neg_q,  neg_d;
  logic [PERM_W-1:0]     perm_q, perm_d;
  logic                  oneg_q, oneg_d;
  logic                  cfg_err_q, cfg_err_d;

  // Pipeline registers
  logic                  s1_valid_q, s1_valid_d;
  logic [NUM_INPUTS-1:0] s1_v_q,     s1_v_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_y_q,     s2_y_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;

  // Handshake terms
  logic                  s2_free;
  logic                  s1_adv;
  logic                  in_fire;
  logic                  cfg_fire;
  logic                  cfg_good;
  logic                  out_fire;
  logic [NUM_INPUTS-1:0] xf_y;

  npn_xform #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_xform (
    .x    (in_x),
    .neg  (neg_q),
    .perm (perm_q),
    .y    (xf_y)
  );

  always_comb begin
    // Stage 2 can take new data when empty or when its result leaves this cycle.
    s2_free   = ~s2_valid_q | out_ready;
    s1_adv    = s1_valid_q & s2_free;
    // A pending configuration starves inputs so the pipeline empties and the
    // configuration is eventually accepted.
    in_ready  = ~rst & ~cfg_valid & (~s1_valid_q | s2_free);
    cfg_ready = ~rst & ~s1_valid_q & ~s2_valid_q;
    in_fire   = in_valid & in_ready;
    cfg_fire  = cfg_valid & cfg_ready;
    cfg_good  = perm_ok(perm_vec_t'(cfg_perm), NUM_INPUTS);
    out_fire  = s2_valid_q & out_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_v_d     = s1_v_q;
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    cnt_d      = cnt_q;
    tt_d       = tt_q;
    neg_d      = neg_q;
    perm_d     = perm_q;
    oneg_d     = oneg_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_v_d     = xf_y;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // out_y only changes when a new result loads, so it stays put under
    // backpressure and after the last result drains.
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_y_d = tt_q[s1_v_q] ^ oneg_q;
    end

    if (out_fire && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

    // A rejected configuration completes its handshake but leaves state alone.
    if (cfg_fire && cfg_good) begin
      tt_d   = cfg_tt;
      neg_d  = cfg_neg;
      perm_d = cfg_perm;
      oneg_d = cfg_oneg;
    end
    cfg_err_d = cfg_fire & ~cfg_good;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_q       <= RST_TT;
      neg_q      <= '0;
      perm_q     <= RST_PERM;
      oneg_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_v_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tt_q       <= tt_d;
      neg_q      <= neg_d;
      perm_q     <= perm_d;
      oneg_q     <= oneg_d;
      cfg_err_q  <= cfg_err_d;
      s1_valid_q <= s1_valid_d;
      s1_v_q     <= s1_v_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_y      = s2_y_q;
  assign cfg_err    = cfg_err_q;
  assign eval_count = cnt_q;

endmodule

// File: doc/npn_lut_stream.md
Name: npn_lut_stream

Overview:
- Pipelined, streaming evaluator for one N-input Boolean function held as a programmable truth table, plus a runtime NPN transform.
- The transform is an input-negation mask, an input permutation and an output negation.
- Successor to the fixed 4-input exact-AIG function blocks. One instance can evaluate any NPN-class member at runtime over a valid/ready stream.
- Reset default configuration reproduces truth table 16'h1689 with an identity transform.

Parameters:
NUM_INPUTS, 4, number of function inputs (2..6)
TT_W, 2**NUM_INPUTS, truth-table width (derived, do not override)
IDX_W, $clog2(NUM_INPUTS), permutation index width (derived)
DEFAULT_TT, 16'h1689 (zero-extended/truncated to TT_W), truth table loaded at reset
CNT_W, 16, width of evaluation counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted this cycle when both high
cfg_tt  in  TT_W  truth table; bit i = f(index i), index bit k = input k
cfg_neg  in  NUM_INPUTS  input negation mask
cfg_perm  in  NUM_INPUTS*IDX_W  field k = source input index for transformed input k
cfg_oneg  in  1  output negation
cfg_err  out  1  one-cycle pulse: accepted config rejected (bad permutation)
in_valid  in  1  input vector offered
in_ready  out  1  input accepted when both high
in_x  in  NUM_INPUTS  input vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_y  out  1  result
eval_count  out  CNT_W  saturating count of results delivered (out_valid & out_ready)

Behaviour:
- Reset (async, rst=1):
  - tt = DEFAULT_TT, neg = 0, perm = identity (field k = k), oneg = 0.
  - Both stage valids = 0; out_valid = 0, out_y = 0, cfg_err = 0, eval_count = 0.
  - in_ready = 0 and cfg_ready = 0 while rst is high.
- Stage 1 (transform), registered on input accept: v = in_x ^ neg; s1_v[k] = v[perm field k].
- Stage 2 (lookup): out_y = tt[s1_v] ^ oneg.
- Latency is exactly 2 cycles from input handshake to out_valid with no backpressure.
- Throughput is 1 per cycle.
- Elastic pipeline:
  - A stage loads when it is empty or its contents advance the same cycle.
  - in_ready = ~s1_valid | (s2 advancing or empty).
  - out_valid holds, and out_y is stable, while out_ready = 0.
  - No combinational path from in_valid to out_valid. in_ready may depend combinationally on out_ready.
- Configuration:
  - cfg_ready = 1 only when both stages are empty and rst = 0.
  - While cfg_valid = 1, in_ready is forced 0 so the pipeline drains; this guarantees config is never starved.
  - Config takes effect for vectors accepted the cycle after the cfg handshake. In-flight vectors always use the config they entered under, since the pipeline is empty at accept.
  - Permutation check: every field must be < NUM_INPUTS and no value may be repeated.
  - On a violation the handshake still completes, no register changes, and cfg_err = 1 for exactly the next cycle.
- eval_count increments on each output handshake and saturates at all-ones (no wrap).
- Simultaneous cfg_valid and in_valid with the pipeline empty: config wins; in_ready = 0 that cycle.
- Reset mid-stream: all in-flight results are discarded; no out_valid until a new input is accepted after rst deasserts.

Decomposition:
- Package npn_pkg:
  - DEFAULT_TT_4IN = 16'h1689.
  - Function idx_w(n).
  - Function perm_ok(perm, n), returning validity.
  - Function identity_perm(n).
- One sub-module, npn_xform: combinational negate+permute of NUM_INPUTS bits, instantiated in stage 1.
- Lookup, handshake and counter live in the top.

Test Plan:
- Reset defaults, identity transform: stream in_x = 0..15 with out_ready = 1. Outputs appear 2 cycles after each accept and form 1,0,0,1,0,0,0,1,0,1,1,0,1,0,0,0 (= 16'h1689 LSB-first); eval_count = 16.
- Negation: cfg neg = 4'b0001, tt = 16'h1689, identity perm. Then in_x = 0 -> out_y = 0 (tt[1]), and in_x = 1 -> out_y = 1 (tt[0]).
- Permutation and output negation: perm swaps inputs 0 and 3 (fields 3,1,2,0), oneg = 1. Then in_x = 4'b0001 -> index 8 -> out_y = ~0 = 1.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1. Exactly 2 vectors are accepted; in_ready = 0 after that; out_y is stable. On release, results drain in order with no loss or duplicates.
- Bad config: perm fields 0,0,2,3 offered while the pipeline is busy. cfg_ready stays low until drain, then the handshake completes, cfg_err pulses for 1 cycle, and subsequent results still follow the prior config.
- Saturation and reset: with CNT_W = 4, deliver 20 results -> eval_count = 15. Assert rst with 2 vectors in flight -> out_valid = 0 immediately and eval_count = 0.
